scomp_io_timer: RTL and testbench

SCOMP_IO_TIMER -- requirements
Module: scomp_io_timer

---
 rtl/scomp_io_timer.sv | 131 +++++++++++++
 tb/tb_scomp_io_timer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scomp_io_timer.sv
// scomp_io_timer: SCOMP IO-mapped 16-bit timer with CTRL/PERIOD/COUNT/STATUS registers and a level IRQ.
// Latency: writes commit on the IO cycle-start clock; read data is driven 1 clock after cycle start; o_irq 1 clock after EXPIRED/IRQEN.
// Backpressure: none; the IO cycle length is set by the bridge, read data is held until i_sc_iocyc falls.
// Ports: i_clk / i_reset (sync, active-high); i_sc_iocyc, i_sc_iowr, i_sc_ioaddr from the Wishbone-to-SCOMP bridge;
//        io_sc_iodata shared 16-bit data bus (driven only during a hit read); o_irq registered interrupt (EXPIRED && IRQEN).
module scomp_io_timer #(
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter int         TICK_DIV  = 100
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sc_iocyc,
    input  logic        i_sc_iowr,
    input  logic [7:0]  i_sc_ioaddr,
    inout  wire  [15:0] io_sc_iodata,
    output logic        o_irq
);

    localparam logic [15:0] PRESCALE_MAX = 16'(TICK_DIV - 1);

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PERIOD = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic        iocyc_q;
    logic        rd_active_q;
    logic [15:0] rdata_q;
    logic [15:0] rd_mux;

    logic        en;
    logic        autoreload;
    logic        irqen;
    logic        expired;
    logic [15:0] period;
    logic [15:0] count;
    logic [15:0] prescale;

    logic        hit;
    logic [1:0]  offset;
    logic        cyc_start;
    logic        wr_commit;
    logic        rd_commit;
    logic        tick;
    logic        expire;

    assign hit       = (i_sc_ioaddr[7:2] == BASE_ADDR[7:2]);
    assign offset    = i_sc_ioaddr[1:0];
    // A cycle is serviced once, on its first clock; a cycle already in progress
    // when reset releases looks like a fresh start because iocyc_q resets low.
    assign cyc_start = i_sc_iocyc && !iocyc_q;
    assign wr_commit = cyc_start && hit && i_sc_iowr;
    assign rd_commit = cyc_start && hit && !i_sc_iowr;

    assign tick   = (prescale == PRESCALE_MAX);
    // PERIOD==0 never expires; COUNT simply wraps through 16'hFFFF.
    assign expire = tick && en && (period != 16'd0) && (count == period - 16'd1);

    always_comb begin
        rd_mux = 16'd0;
        case (offset)
            OFF_CTRL:   rd_mux = {13'd0, irqen, autoreload, en};
            OFF_PERIOD: rd_mux = period;
            OFF_COUNT:  rd_mux = count;
            OFF_STATUS: rd_mux = {14'd0, en, expired};
            default:    rd_mux = 16'd0;
        endcase
    end

    // Release is combinational on i_sc_iocyc so the bus frees the instant the cycle ends.
    assign io_sc_iodata = (rd_active_q && i_sc_iocyc && !i_sc_iowr) ? rdata_q : 16'hzzzz;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            iocyc_q     <= 1'b0;
            rd_active_q <= 1'b0;
            rdata_q     <= 16'd0;
            en          <= 1'b0;
            autoreload  <= 1'b0;
            irqen       <= 1'b0;
            expired     <= 1'b0;
            period      <= 16'd0;
            count       <= 16'd0;
            prescale    <= 16'd0;
            o_irq       <= 1'b0;
        end else begin
            iocyc_q  <= i_sc_iocyc;
            prescale <= tick ? 16'd0 : prescale + 16'd1;

            // A bus write to CTRL overrides the one-shot EN clear from a coincident expiry.
            if (wr_commit && offset == OFF_CTRL) begin
                {irqen, autoreload, en} <= io_sc_iodata[2:0];
            end else if (expire && !autoreload) begin
                en <= 1'b0;
            end

            if (wr_commit && offset == OFF_PERIOD) begin
                period <= io_sc_iodata;
            end

            if (wr_commit && offset == OFF_COUNT) begin
                count <= io_sc_iodata;
            end else if (tick && en) begin
                if (expire) begin
                    count <= autoreload ? 16'd0 : period;
                end else begin
                    count <= count + 16'd1;
                end
            end

            // Expiry beats a simultaneous write-1-to-clear so no event is lost.
            if (expire) begin
                expired <= 1'b1;
            end else if (wr_commit && offset == OFF_STATUS && io_sc_iodata[0]) begin
                expired <= 1'b0;
            end

            o_irq <= expired && irqen;

            if (cyc_start) begin
                rd_active_q <= rd_commit;
                if (rd_commit) begin
                    rdata_q <= rd_mux;
                end
            end else if (!i_sc_iocyc) begin
                rd_active_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scomp_io_timer.sv
// tb_scomp_io_timer: bench for scomp_io_timer (TICK_DIV=4, BASE_ADDR=8'h10).
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_scomp_io_timer;

    localparam int          TD   = 4;
    localparam logic [7:0]  BASE = 8'h10;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        iocyc  = 1'b0;
    logic        iowr   = 1'b0;
    logic [7:0]  addr   = 8'h00;
    logic        tb_oe  = 1'b0;
    logic [15:0] tb_dat = 16'h0000;
    wire  [15:0] bus;
    logic        irq;

    int   n_vec  = 0;
    int   n_fail = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    assign bus = tb_oe ? tb_dat : 16'hzzzz;
    pullup (bus);

    scomp_io_timer #(.BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_sc_iocyc   (iocyc),
        .i_sc_iowr    (iowr),
        .i_sc_ioaddr  (addr),
        .io_sc_iodata (bus),
        .o_irq        (irq)
    );

    // ---------------- reference model ----------------
    int          m_clks;
    logic        m_iocyc_q, m_en, m_auto, m_irqen, m_expired, m_irq, m_rd_on;
    logic [15:0] m_period, m_count, m_rd_val;
    logic        m_start, m_hit, m_tick, m_wr, m_expire;
    logic [1:0]  m_off;

    assign m_start  = iocyc && !m_iocyc_q;
    assign m_hit    = (addr[7:2] == BASE[7:2]);
    assign m_off    = addr[1:0];
    assign m_wr     = m_start && m_hit && iowr;
    assign m_tick   = (m_clks % TD) == (TD - 1);
    assign m_expire = m_tick && m_en && (m_period != 16'd0) && (int'(m_count) + 1 == int'(m_period));

    function automatic logic [15:0] m_reg(input logic [1:0] off);
        case (off)
            2'd0:    return {13'd0, m_irqen, m_auto, m_en};
            2'd1:    return m_period;
            2'd2:    return m_count;
            default: return {14'd0, m_en, m_expired};
        endcase
    endfunction

    function automatic logic [15:0] exp_bus();
        return m_rd_on ? m_rd_val : 16'hFFFF;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_clks <= 0; m_iocyc_q <= 1'b0; m_en <= 1'b0; m_auto <= 1'b0; m_irqen <= 1'b0;
            m_expired <= 1'b0; m_irq <= 1'b0; m_rd_on <= 1'b0; m_period <= 16'd0;
            m_count <= 16'd0; m_rd_val <= 16'd0;
        end else begin
            m_clks    <= m_clks + 1;
            m_iocyc_q <= iocyc;
            if (m_wr && m_off == 2'd0) {m_irqen, m_auto, m_en} <= tb_dat[2:0];
            else if (m_expire && !m_auto) m_en <= 1'b0;
            if (m_wr && m_off == 2'd1) m_period <= tb_dat;
            if (m_wr && m_off == 2'd2) m_count <= tb_dat;
            else if (m_tick && m_en)
                m_count <= m_expire ? (m_auto ? 16'd0 : m_period) : 16'((int'(m_count) + 1) % 65536);
            if (m_expire) m_expired <= 1'b1;
            else if (m_wr && m_off == 2'd3 && tb_dat[0]) m_expired <= 1'b0;
            m_irq <= m_expired && m_irqen;
            if (m_start) begin
                m_rd_on <= m_hit && !iowr;
                if (m_hit && !iowr) m_rd_val <= m_reg(m_off);
            end else if (!iocyc) begin
                m_rd_on <= 1'b0;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) chk("irq", {15'd0, irq}, {15'd0, m_irq});
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; iocyc = 1'b0; iowr = 1'b0; tb_oe = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        iocyc = 1'b1; iowr = 1'b1; addr = a; tb_oe = 1'b1; tb_dat = d;
        @(negedge clk);
        tb_oe = 1'b0;
        #1 chk("wr_hiz", bus, 16'hFFFF);
        iocyc = 1'b0; iowr = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, input int hold, output logic [15:0] v);
        v = 16'h0000;
        @(negedge clk);
        iocyc = 1'b1; iowr = 1'b0; addr = a; tb_oe = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("rd_bus", bus, exp_bus());
            if (h == 0) v = bus;
        end
        iocyc = 1'b0;
        #1 chk("rd_release", bus, 16'hFFFF);
    endtask

    // Leaves the bench so that the next bus_write commits on a tick clock.
    task automatic align_tick();
        @(negedge clk);
        for (int i = 0; i < TD && (m_clks % TD) != (TD - 2); i++) @(negedge clk);
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  a;
        logic [15:0] d;
        logic [15:0] exp;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[19];
        logic [15:0] v;
        int          r;
        logic [7:0]  a;
        logic [15:0] d;

        tbl = '{
            '{1'b0, 8'h10, 16'h0000, 16'h0000},
            '{1'b0, 8'h11, 16'h0000, 16'h0000},
            '{1'b0, 8'h12, 16'h0000, 16'h0000},
            '{1'b0, 8'h13, 16'h0000, 16'h0000},
            '{1'b1, 8'h11, 16'h1234, 16'h0000},
            '{1'b0, 8'h11, 16'h0000, 16'h1234},
            '{1'b1, 8'h12, 16'hABCD, 16'h0000},
            '{1'b0, 8'h12, 16'h0000, 16'hABCD},
            '{1'b1, 8'h10, 16'hFFFA, 16'h0000},
            '{1'b0, 8'h10, 16'h0000, 16'h0002},
            '{1'b1, 8'h13, 16'hFFFF, 16'h0000},
            '{1'b0, 8'h13, 16'h0000, 16'h0000},
            '{1'b1, 8'h14, 16'h5555, 16'h0000},
            '{1'b0, 8'h11, 16'h0000, 16'h1234},
            '{1'b0, 8'h14, 16'h0000, 16'hFFFF},
            '{1'b1, 8'h0F, 16'h0001, 16'h0000},
            '{1'b0, 8'h10, 16'h0000, 16'h0002},
            '{1'b1, 8'h10, 16'h0000, 16'h0000},
            '{1'b0, 8'h12, 16'h0000, 16'hABCD}
        };

        do_reset();
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_bus", bus, 16'hFFFF);

        // register access table (timer never enabled, so values are static)
        foreach (tbl[i]) begin
            if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].d);
            else begin
                bus_read(tbl[i].a, 2, v);
                chk($sformatf("tbl%0d", i), v, tbl[i].exp);
            end
        end

        // auto-reload: PERIOD=5, CTRL=3
        do_reset();
        bus_write(8'h11, 16'd5);
        bus_write(8'h10, 16'h0003);
        for (int i = 0; i < 12; i++) bus_read(8'h12, 1, v);
        repeat (10) @(negedge clk);
        bus_read(8'h13, 1, v); chk("ar_status", v, 16'h0003);
        bus_read(8'h10, 1, v); chk("ar_ctrl", v, 16'h0003);
        bus_read(8'h12, 8, v);

        // one-shot with IRQ: PERIOD=3, CTRL=5
        do_reset();
        bus_write(8'h11, 16'd3);
        bus_write(8'h10, 16'h0005);
        repeat (18) @(negedge clk);
        bus_read(8'h12, 1, v); chk("os_count", v, 16'h0003);
        bus_read(8'h10, 1, v); chk("os_ctrl", v, 16'h0004);
        chk("os_irq_set", {15'd0, irq}, 16'd1);
        bus_write(8'h13, 16'h0001);
        chk("os_irq_hold", {15'd0, irq}, 16'd1);
        @(negedge clk);
        chk("os_irq_clr", {15'd0, irq}, 16'd0);

        // bus write vs tick, STATUS clear vs expiry
        do_reset();
        bus_write(8'h11, 16'd0);
        bus_write(8'h10, 16'h0001);
        align_tick();
        bus_write(8'h12, 16'h0007);
        bus_read(8'h12, 1, v); chk("wr_tick_count", v, 16'h0007);
        bus_write(8'h11, 16'd2);
        align_tick();
        bus_write(8'h12, 16'h0001);
        align_tick();
        bus_write(8'h13, 16'h0001);
        bus_read(8'h13, 1, v); chk("clr_vs_exp_status", v, 16'h0001);
        bus_read(8'h12, 1, v); chk("clr_vs_exp_count", v, 16'h0002);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            a = BASE | 8'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                a = 8'($urandom);
                if (a[7:2] == BASE[7:2]) a[2] = ~a[2];
            end
            if (r < 4) begin
                case (a[1:0])
                    2'd0:    d = 16'($urandom_range(0, 7)) | (($urandom_range(0, 2) != 0) ? 16'd1 : 16'd0);
                    2'd1:    d = 16'($urandom_range(0, 9));
                    2'd2:    d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 9));
                    default: d = 16'($urandom);
                endcase
                bus_write(a, d);
            end else if (r < 8) begin
                bus_read(a, $urandom_range(1, 5), v);
            end else begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
            end
        end

        // reset in the middle of a read, then resume with i_sc_iocyc still high
        bus_write(8'h11, 16'd0);
        bus_write(8'h12, 16'h00F0);
        bus_write(8'h10, 16'h0007);
        @(negedge clk);
        iocyc = 1'b1; iowr = 1'b0; addr = 8'h12;
        @(negedge clk);
        chk("mid_rd_bus", bus, exp_bus());
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rd_hiz", bus, 16'hFFFF);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_resume_rd", bus, 16'h0000);
        iocyc = 1'b0;
        #1 chk("rst_resume_release", bus, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            bus_read(BASE | 8'(i), 1, v);
            chk($sformatf("rst_reg%0d", i), v, 16'h0000);
        end
        bus_write(8'h11, 16'd9);
        bus_read(8'h11, 1, v); chk("post_rst_period", v, 16'd9);

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
